// File: rtl/prach_pkg.sv
// Shared types for the PRACH Avalon-ST source packer: FSM states, lane geometry
// and the beat record carried through the output FIFO.
package prach_pkg;
    localparam int LANES = 4;
    localparam int SMP_W = 32;
    localparam int CHN_W = 16;

    typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

    typedef struct packed {
        logic [LANES*SMP_W-1:0] data;
        logic [CHN_W-1:0]       chn;
        logic                   sop;
        logic                   eop;
        logic [1:0]             empty;
    } beat_t;

    localparam int BEAT_W = $bits(beat_t);
endpackage

// File: rtl/prach_skid_fifo.sv
// Two-entry output queue; entry e0 is always the head so outputs come straight
// from a register.
module prach_skid_fifo #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic [1:0]   count
);
    logic [W-1:0] e0, e1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e0    <= '0;
            e1    <= '0;
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) e0 <= din;
                    else               e1 <= din;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    e0    <= e1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        e0 <= din;
                    end else begin
                        e0 <= e1;
                        e1 <= din;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dout = e0;
endmodule

// File: rtl/prach_avst_source_packer.sv
// Packs 32-bit IQ samples four per 128-bit Avalon-ST beat, tracking packet
// framing per logical channel and flagging framing / channel errors.
module prach_avst_source_packer
    import prach_pkg::*;
#(
    parameter int MAX_CHN = 24
) (
    input  logic         clk_eth_xran,
    input  logic         rst_eth_xran,
    input  logic         din_valid,
    output logic         din_ready,
    input  logic [31:0]  din_data,
    input  logic [15:0]  din_chn,
    input  logic         din_sop,
    input  logic         din_eop,
    output logic [127:0] avst_source_data,
    output logic         avst_source_valid,
    input  logic         avst_source_ready,
    output logic [15:0]  avst_source_channel,
    output logic         avst_source_startofpacket,
    output logic         avst_source_endofpacket,
    output logic [1:0]   avst_source_empty,
    output logic [2:0]   err_flags,
    input  logic         err_clr
);
    state_t                         state, state_n;
    logic [0:LANES-1][SMP_W-1:0]    acc, lane_d;
    logic [1:0]                     cnt, cnt_n, keep, acc_idx, b_empty, fifo_cnt, fcnt_n;
    logic [CHN_W-1:0]               chn_q, chn_n, b_chn;
    logic                           first_q, first_n, drop_q, drop_n, pend_q, pend_n, rdy_q;
    logic                           accept, chn_ok, push, pop, partial, use_din, acc_we, b_sop, b_eop;
    logic [2:0]                     err_q, err_new;
    beat_t                          push_beat, head;

    assign accept = din_valid && rdy_q;
    assign chn_ok = 32'(din_chn) < 32'(MAX_CHN);
    assign pop    = (fifo_cnt != 2'd0) && avst_source_ready;

    always_comb begin
        push    = 1'b0;
        partial = 1'b0;
        keep    = cnt;
        use_din = 1'b0;
        b_sop   = 1'b0;
        b_eop   = 1'b0;
        b_empty = 2'd0;
        b_chn   = chn_q;
        state_n = state;
        cnt_n   = cnt;
        chn_n   = chn_q;
        first_n = first_q;
        drop_n  = drop_q;
        pend_n  = pend_q;
        acc_we  = 1'b0;
        acc_idx = cnt;
        err_new = 3'b000;
        if (pend_q) begin
            // single-sample packet that collided with a partial-beat flush
            if (fifo_cnt != 2'd2) begin
                push    = 1'b1;
                keep    = 2'd1;
                b_sop   = 1'b1;
                b_eop   = 1'b1;
                b_empty = 2'd3;
                pend_n  = 1'b0;
                cnt_n   = 2'd0;
            end
        end else if (accept) begin
            if (din_sop) begin
                if (state == FILL) begin
                    err_new[0] = 1'b1;
                    // cnt==0 means the last beat already left; nothing partial to close
                    if (cnt != 2'd0) begin
                        push    = 1'b1;
                        partial = 1'b1;
                        b_sop   = first_q;
                        b_eop   = 1'b1;
                        b_empty = 2'd0 - cnt;
                    end
                end
                state_n = IDLE;
                cnt_n   = 2'd0;
                drop_n  = 1'b0;
                if (!chn_ok) begin
                    err_new[2] = 1'b1;
                    drop_n     = !din_eop;
                end else if (din_eop) begin
                    if (partial) begin
                        pend_n  = 1'b1;
                        acc_we  = 1'b1;
                        acc_idx = 2'd0;
                        chn_n   = din_chn;
                    end else begin
                        push    = 1'b1;
                        keep    = 2'd0;
                        use_din = 1'b1;
                        b_sop   = 1'b1;
                        b_eop   = 1'b1;
                        b_empty = 2'd3;
                        b_chn   = din_chn;
                    end
                end else begin
                    state_n = FILL;
                    acc_we  = 1'b1;
                    acc_idx = 2'd0;
                    cnt_n   = 2'd1;
                    chn_n   = din_chn;
                    first_n = 1'b1;
                end
            end else if (state == FILL) begin
                if (din_eop || cnt == 2'd3) begin
                    push    = 1'b1;
                    use_din = 1'b1;
                    b_sop   = first_q;
                    b_eop   = din_eop;
                    b_empty = din_eop ? 2'd3 - cnt : 2'd0;
                    first_n = 1'b0;
                    cnt_n   = 2'd0;
                    if (din_eop) state_n = IDLE;
                end else begin
                    acc_we = 1'b1;
                    cnt_n  = cnt + 2'd1;
                end
            end else if (drop_q) begin
                if (din_eop) drop_n = 1'b0;
            end else begin
                err_new[1] = 1'b1;
            end
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign lane_d[l] = (l < int'(keep))                ? acc[l]   :
                           ((l == int'(keep)) && use_din) ? din_data : '0;
    end

    assign push_beat = {lane_d, b_chn, b_sop, b_eop, b_empty};

    always_comb begin
        fcnt_n = fifo_cnt;
        if (push && !pop)      fcnt_n = fifo_cnt + 2'd1;
        else if (!push && pop) fcnt_n = fifo_cnt - 2'd1;
    end

    always_ff @(posedge clk_eth_xran or posedge rst_eth_xran) begin
        if (rst_eth_xran) begin
            state   <= IDLE;
            acc     <= '0;
            cnt     <= 2'd0;
            chn_q   <= '0;
            first_q <= 1'b0;
            drop_q  <= 1'b0;
            pend_q  <= 1'b0;
            rdy_q   <= 1'b0;
            err_q   <= 3'b000;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            chn_q   <= chn_n;
            first_q <= first_n;
            drop_q  <= drop_n;
            pend_q  <= pend_n;
            if (acc_we) acc[acc_idx] <= din_data;
            rdy_q   <= (fcnt_n != 2'd2) && !pend_n;
            err_q   <= err_clr ? 3'b000 : (err_q | err_new);
        end
    end

    prach_skid_fifo #(.W(BEAT_W)) u_fifo (
        .clk   (clk_eth_xran),
        .rst   (rst_eth_xran),
        .push  (push),
        .din   (push_beat),
        .pop   (pop),
        .dout  (head),
        .count (fifo_cnt)
    );

    assign din_ready                 = rdy_q;
    assign avst_source_valid         = fifo_cnt != 2'd0;
    assign avst_source_data          = head.data;
    assign avst_source_channel       = head.chn;
    assign avst_source_startofpacket = head.sop;
    assign avst_source_endofpacket   = head.eop;
    assign avst_source_empty         = head.empty;
    assign err_flags                 = err_q;
endmodule

// File: tb/tb_prach_avst_source_packer.sv
// Scoreboard bench: directed packets push hand-computed beats; a negedge monitor
// pops and compares every beat the DUT hands over, and checks held beats stay put.
module tb_prach_avst_source_packer;
    import prach_pkg::*;

    logic         clk = 1'b0, rst = 1'b1;
    logic         din_valid = 1'b0, din_sop = 1'b0, din_eop = 1'b0, err_clr = 1'b0;
    logic         avst_source_ready = 1'b1;
    logic [31:0]  din_data = '0;
    logic [15:0]  din_chn = '0;
    logic         din_ready, avst_source_valid, avst_source_startofpacket, avst_source_endofpacket;
    logic [127:0] avst_source_data;
    logic [15:0]  avst_source_channel;
    logic [1:0]   avst_source_empty;
    logic [2:0]   err_flags;

    always #5 clk = ~clk;

    prach_avst_source_packer #(.MAX_CHN(24)) dut (
        .clk_eth_xran              (clk),
        .rst_eth_xran              (rst),
        .din_valid                 (din_valid),
        .din_ready                 (din_ready),
        .din_data                  (din_data),
        .din_chn                   (din_chn),
        .din_sop                   (din_sop),
        .din_eop                   (din_eop),
        .avst_source_data          (avst_source_data),
        .avst_source_valid         (avst_source_valid),
        .avst_source_ready         (avst_source_ready),
        .avst_source_channel       (avst_source_channel),
        .avst_source_startofpacket (avst_source_startofpacket),
        .avst_source_endofpacket   (avst_source_endofpacket),
        .avst_source_empty         (avst_source_empty),
        .err_flags                 (err_flags),
        .err_clr                   (err_clr)
    );

    beat_t exp_q[$];
    beat_t cur, held;
    bit    hold_v = 1'b0;
    int    n_chk = 0, n_fail = 0;

    assign cur = {avst_source_data, avst_source_channel, avst_source_startofpacket,
                  avst_source_endofpacket, avst_source_empty};

    task automatic chk(input string nm, input logic [BEAT_W-1:0] act, input logic [BEAT_W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic beat_t mk(input logic [127:0] d, input logic [15:0] c,
                                 input logic s, input logic e, input logic [1:0] em);
        return {d, c, s, e, em};
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                chk("hold_valid", BEAT_W'(avst_source_valid), BEAT_W'(1));
                chk("hold_stable", cur, held);
            end
            if (avst_source_valid && avst_source_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got %h expected none", cur);
                end else begin
                    chk("beat", cur, exp_q.pop_front());
                end
            end
            hold_v = avst_source_valid && !avst_source_ready;
            held   = cur;
        end
    end

    task automatic send(input logic [31:0] d, input logic [15:0] c, input logic s, input logic e);
        bit r;
        int t;
        t = 0;
        din_valid = 1'b1; din_data = d; din_chn = c; din_sop = s; din_eop = e;
        do begin
            @(negedge clk); r = din_ready;
            @(posedge clk); #1;
            t++;
        end while (!r && t < 200);
        if (!r) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_timeout: din_ready stayed 0, required 1");
        end
        din_valid = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(posedge clk);
            t++;
        end
        @(posedge clk); #1;
        chk("drain_left", BEAT_W'(exp_q.size()), BEAT_W'(0));
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        chk("err_clear", BEAT_W'(err_flags), BEAT_W'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        chk("rst_ctrl", BEAT_W'({avst_source_valid, din_ready, err_flags, avst_source_startofpacket,
                                 avst_source_endofpacket, avst_source_empty, avst_source_channel}), BEAT_W'(0));
        chk("rst_data", BEAT_W'(avst_source_data), BEAT_W'(0));
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_rst", BEAT_W'(din_ready), BEAT_W'(1));

        // 8 samples, chn 5
        exp_q.push_back(mk(128'h10000000_10000001_10000002_10000003, 16'd5, 1'b1, 1'b0, 2'd0));
        exp_q.push_back(mk(128'h10000004_10000005_10000006_10000007, 16'd5, 1'b0, 1'b1, 2'd0));
        for (int k = 0; k < 8; k++) send(32'h1000_0000 + 32'(k), 16'd5, k == 0, k == 7);
        drain();

        // 6 samples, chn 7: two empty lanes on the eop beat
        exp_q.push_back(mk(128'h20000000_20000001_20000002_20000003, 16'd7, 1'b1, 1'b0, 2'd0));
        exp_q.push_back(mk(128'h20000004_20000005_00000000_00000000, 16'd7, 1'b0, 1'b1, 2'd2));
        for (int k = 0; k < 6; k++) send(32'h2000_0000 + 32'(k), 16'd7, k == 0, k == 5);
        drain();

        // single-sample packet, chn 0
        exp_q.push_back(mk(128'h30000000_00000000_00000000_00000000, 16'd0, 1'b1, 1'b1, 2'd3));
        send(32'h3000_0000, 16'd0, 1'b1, 1'b1);
        drain();

        // 16 samples with the sink stalled for 20 cycles
        exp_q.push_back(mk(128'h40000000_40000001_40000002_40000003, 16'd2, 1'b1, 1'b0, 2'd0));
        exp_q.push_back(mk(128'h40000004_40000005_40000006_40000007, 16'd2, 1'b0, 1'b0, 2'd0));
        exp_q.push_back(mk(128'h40000008_40000009_4000000a_4000000b, 16'd2, 1'b0, 1'b0, 2'd0));
        exp_q.push_back(mk(128'h4000000c_4000000d_4000000e_4000000f, 16'd2, 1'b0, 1'b1, 2'd0));
        avst_source_ready = 1'b0;
        fork
            begin
                for (int k = 0; k < 16; k++) send(32'h4000_0000 + 32'(k), 16'd2, k == 0, k == 15);
            end
            begin
                repeat (15) @(posedge clk);
                #2;
                chk("backpressure", BEAT_W'({din_ready, avst_source_valid}), BEAT_W'(2'b01));
                repeat (5) @(posedge clk);
                #2;
                avst_source_ready = 1'b1;
            end
        join
        drain();

        // sop after 3 samples: partial beat closes the old packet
        exp_q.push_back(mk(128'h50000000_50000001_50000002_00000000, 16'd3, 1'b1, 1'b1, 2'd1));
        exp_q.push_back(mk(128'h60000000_60000001_60000002_60000003, 16'd4, 1'b1, 1'b1, 2'd0));
        for (int k = 0; k < 3; k++) send(32'h5000_0000 + 32'(k), 16'd3, k == 0, 1'b0);
        for (int k = 0; k < 4; k++) send(32'h6000_0000 + 32'(k), 16'd4, k == 0, k == 3);
        drain();
        chk("err_sop_mid", BEAT_W'(err_flags), BEAT_W'(3'b001));
        clear_err();

        // data outside a packet is dropped
        send(32'h7000_0000, 16'd1, 1'b0, 1'b0);
        drain();
        chk("err_no_sop", BEAT_W'(err_flags), BEAT_W'(3'b010));
        clear_err();

        // illegal channel drops the whole packet; following legal packet survives
        exp_q.push_back(mk(128'h90000000_00000000_00000000_00000000, 16'd9, 1'b1, 1'b1, 2'd3));
        send(32'h8000_0000, 16'd24, 1'b1, 1'b0);
        send(32'h8000_0001, 16'd24, 1'b0, 1'b0);
        send(32'h8000_0002, 16'd24, 1'b0, 1'b1);
        send(32'h9000_0000, 16'd9, 1'b1, 1'b1);
        drain();
        chk("err_bad_chn", BEAT_W'(err_flags), BEAT_W'(3'b100));
        clear_err();

        // clear wins over an error raised in the same cycle
        err_clr = 1'b1;
        send(32'h7000_0001, 16'd0, 1'b0, 1'b0);
        err_clr = 1'b0;
        @(posedge clk); #1;
        chk("err_clr_priority", BEAT_W'(err_flags), BEAT_W'(0));

        // reset mid-packet, then a fresh 4-sample packet
        send(32'hB000_0000, 16'd1, 1'b1, 1'b0);
        send(32'hB000_0001, 16'd1, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk("midrst_out", BEAT_W'({avst_source_valid, din_ready, err_flags}), BEAT_W'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("midrst_ready", BEAT_W'(din_ready), BEAT_W'(1));
        exp_q.push_back(mk(128'hC0000000_C0000001_C0000002_C0000003, 16'd6, 1'b1, 1'b1, 2'd0));
        for (int k = 0; k < 4; k++) send(32'hC000_0000 + 32'(k), 16'd6, k == 0, k == 3);
        drain();
        repeat (4) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/prach_avst_source_packer.md
PRACH_AVST_SOURCE_PACKER -- requirements
Module: prach_avst_source_packer

Interface
REQ-001 SHALL have parameter MAX_CHN, default 24, meaning the number of logical channels (ant*3+cc); din_chn values at or above MAX_CHN are illegal.
REQ-002 SHALL have port clk_eth_xran, input, 1 bit: the single clock.
REQ-003 SHALL have port rst_eth_xran, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have ports din_valid (in, 1), din_ready (out, 1), din_data (in, 32, {Q[15:0], I[15:0]}), din_chn (in, 16), din_sop (in, 1) and din_eop (in, 1).
REQ-005 SHALL have ports avst_source_data (out, 128), avst_source_valid (out, 1), avst_source_ready (in, 1), avst_source_channel (out, 16), avst_source_startofpacket (out, 1), avst_source_endofpacket (out, 1) and avst_source_empty (out, 2, unused 32-bit lanes in an eop beat).
REQ-006 SHALL have port err_flags, out, 3 bits, sticky: [0] sop mid-packet, [1] data outside a packet, [2] din_chn >= MAX_CHN.
REQ-007 SHALL have port err_clr, in, 1 bit: single-cycle clear of err_flags.

Function
REQ-008 SHALL treat a sample as accepted when din_valid and din_ready are both high on a clock edge.
REQ-009 SHALL pack four accepted 32-bit samples into one 128-bit beat; the first sample goes to [127:96] and the last to [31:0].
REQ-010 SHALL have states IDLE and FILL; IDLE->FILL on an accepted din_sop; FILL->IDLE on an accepted din_eop; both din_sop and din_eop on one sample -> single-sample packet, state stays IDLE.
REQ-011 SHALL latch din_chn on the sop sample and drive it on avst_source_channel for every beat of that packet; mid-packet din_chn changes are ignored.
REQ-012 SHALL set avst_source_startofpacket only on the first beat of a packet and avst_source_endofpacket only on the beat holding the eop sample.
REQ-013 SHALL, on eop with k samples in the beat (k=1..4), zero the unused lanes and set avst_source_empty = 4-k; empty SHALL be 0 on every non-eop beat.
REQ-014 SHALL push completed beats into a 2-entry output FIFO, one push per cycle at most.
REQ-015 SHALL drive din_ready from a registered FIFO count: din_ready = (count < 2); no combinational path from avst_source_ready to din_ready.
REQ-016 SHALL follow Avalon-ST readyLatency 0: the head beat is held stable while valid && !ready, and popped on valid && ready.
REQ-017 SHALL allow push and pop in the same cycle, leaving count unchanged.
REQ-018 SHALL give 1-cycle latency from the accepted beat-completing sample to avst_source_valid when the FIFO is empty.
REQ-019 SHALL, on din_sop while in FILL, emit the partial beat with eop=1 and correct empty, set err_flags[0], and start the new packet with the sop sample in lane 0.
REQ-020 SHALL drop a sample received in IDLE without sop and set err_flags[1].
REQ-021 SHALL, on an illegal din_chn at sop, drop the whole packet up to and including its eop and set err_flags[2].
REQ-022 SHALL give err_clr priority over a simultaneous new error in the same cycle; the new error is then lost.

Reset
REQ-023 SHALL, on rst_eth_xran, immediately drive avst_source_valid, sop, eop, empty, channel, data and err_flags to 0, din_ready to 0, set state to IDLE and flush the FIFO and accumulator.
REQ-024 SHALL drive din_ready to 1 on the first clock edge after reset deasserts.
REQ-025 SHALL discard a packet in progress when reset is asserted mid-packet; no eop beat is emitted for it.

Structure
REQ-026 SHALL put the state enum, the lane count (4) and the sample width (32) in the shared package prach_pkg.
REQ-027 SHALL implement the 2-entry FIFO as the sub-module prach_skid_fifo, parameterised by width and carrying data, channel, sop, eop and empty.

Verification
REQ-028 SHALL test an 8-sample packet on chn 5 with ready held high -> 2 beats, chn=5, sop on beat 1, eop on beat 2, empty=0, lane order per REQ-009.
REQ-029 SHALL test a 6-sample packet -> beat 2 carries eop, empty=2, lanes [63:0] zero.
REQ-030 SHALL test a single sample with sop and eop on chn 0 -> 1 beat with sop=eop=1, empty=3.
REQ-031 SHALL test avst_source_ready held low for 20 cycles during a 16-sample stream -> din_ready low once 2 beats are queued, no beat lost or duplicated, data held stable.
REQ-032 SHALL test sop after 3 samples of a packet -> partial beat with eop and empty=1, err_flags=3'b001, new packet correct.
REQ-033 SHALL test reset asserted mid-packet, then a fresh 4-sample packet -> exactly one beat, sop=eop=1, empty=0.
